// File: rtl/igbt_pkg.sv
// Shared types and default timing constants for the IGBT pulse scheduler.
package igbt_pkg;

  localparam int CLK_PER_US_DEF = 50;
  localparam int ACK_US_DEF     = 2;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF_WAIT,
    FAULT
  } chan_state_t;

endpackage

// File: rtl/igbt_pulse_chan.sv
// One gate-drive channel: timed on-pulse, status acknowledge supervision and fault latch.
module igbt_pulse_chan
  import igbt_pkg::*;
#(
  parameter int TW     = 24,
  parameter int ACK_US = ACK_US_DEF
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          tick,
  input  logic          start,
  input  logic [TW-1:0] on_us,
  input  logic          abort,
  input  logic          status,
  input  logic          fault_clr,
  output logic          en,
  output logic          busy,
  output logic          fault,
  output logic          done_pulse
);

  localparam int AW = $clog2(ACK_US + 1);
  localparam logic [AW-1:0] ACK_MAX = AW'(ACK_US);

  chan_state_t   state, state_nxt;
  logic [TW-1:0] on_cnt, on_cnt_nxt;
  logic [AW-1:0] ack_cnt, ack_cnt_nxt, ack_inc;
  logic          seen, seen_nxt;
  logic          done_nxt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      on_cnt     <= '0;
      ack_cnt    <= '0;
      seen       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      on_cnt     <= on_cnt_nxt;
      ack_cnt    <= ack_cnt_nxt;
      seen       <= seen_nxt;
      done_pulse <= done_nxt;
    end
  end

  // Ack counter value including this cycle's tick, so the window closes on the tick itself.
  always_comb begin
    ack_inc = ack_cnt;
    if (tick && ack_cnt != ACK_MAX) ack_inc = ack_cnt + 1'b1;
  end

  always_comb begin
    state_nxt   = state;
    on_cnt_nxt  = on_cnt;
    ack_cnt_nxt = ack_cnt;
    seen_nxt    = seen;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (status) begin
          state_nxt = FAULT;
        end else if (start) begin
          if (on_us == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt   = ON;
            on_cnt_nxt  = on_us;
            ack_cnt_nxt = '0;
            seen_nxt    = 1'b0;
          end
        end
      end
      ON: begin
        if (tick && on_cnt != '0) on_cnt_nxt = on_cnt - 1'b1;
        if (!seen) ack_cnt_nxt = ack_inc;
        if (status) seen_nxt = 1'b1;
        // Status dropping after it rose, or never rising within the window, is a fault.
        if ((seen && !status) || (!seen && !status && ack_inc == ACK_MAX)) begin
          state_nxt = FAULT;
        end else if (abort || on_cnt_nxt == '0) begin
          state_nxt   = OFF_WAIT;
          ack_cnt_nxt = '0;
        end
      end
      OFF_WAIT: begin
        if (!status) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          ack_cnt_nxt = ack_inc;
          if (ack_inc == ACK_MAX) state_nxt = FAULT;
        end
      end
      FAULT: begin
        if (fault_clr && !status) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign en    = (state == ON);
  assign busy  = (state != IDLE);
  assign fault = (state == FAULT);

endmodule

// File: rtl/igbt_pulse_sched.sv
// Command-side IGBT pulse scheduler: shared µs prescaler, request decode and per-channel supervisors.
module igbt_pulse_sched
  import igbt_pkg::*;
#(
  parameter int NCH        = 5,
  parameter int CLK_PER_US = CLK_PER_US_DEF,
  parameter int TW         = 24,
  parameter int ACK_US     = ACK_US_DEF
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_ch,
  input  logic [TW-1:0]  cmd_on_us,
  input  logic           abort,
  output logic [NCH-1:0] IGBT_on_EN,
  input  logic [NCH-1:0] IGBT_status,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done_pulse,
  output logic [NCH-1:0] fault,
  input  logic           fault_clr,
  output logic           cmd_err
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_US - 1);

  logic [PW-1:0]  presc;
  logic           tick;
  logic           ch_oor;
  logic           sel_free;
  logic           accept;
  logic [NCH-1:0] start;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   presc <= '0;
    else if (tick)    presc <= '0;
    else              presc <= presc + 1'b1;
  end

  assign tick = (presc == PRESC_MAX);

  // Out-of-range requests are always taken so the requester never stalls; they are dropped.
  assign ch_oor = ({1'b0, cmd_ch} >= 4'(NCH));

  always_comb begin
    sel_free = 1'b0;
    start    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cmd_ch == 3'(i)) begin
        sel_free = !busy[i] && !fault[i];
        start[i] = accept && !ch_oor;
      end
    end
  end

  assign cmd_ready = !abort && (ch_oor || sel_free);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cmd_err <= 1'b0;
    else            cmd_err <= accept && ch_oor;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    igbt_pulse_chan #(
      .TW     (TW),
      .ACK_US (ACK_US)
    ) u_chan (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .tick       (tick),
      .start      (start[g]),
      .on_us      (cmd_on_us),
      .abort      (abort),
      .status     (IGBT_status[g]),
      .fault_clr  (fault_clr),
      .en         (IGBT_on_EN[g]),
      .busy       (busy[g]),
      .fault      (fault[g]),
      .done_pulse (done_pulse[g])
    );
  end

endmodule
